riscv_issue_ctrl: RTL
=====================

Name: riscv_issue_ctrl

Overview:
- Issue/hazard controller between the decode stage and the execute stage of the RISC-V pipeline.
- Tracks in-flight load destinations in a per-register countdown scoreboard and stalls decode on load-use hazards. ALU-to-ALU hazards are left to forwarding.
- Kills the decode-stage instruction for a fixed number of cycles after a taken branch/jump flush.
- Produces the valid/ready handshake on both sides of the decode stage.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked; x0 is never tracked.
- LOAD_LAT, 2, issue-to-forwardable latency of a load, in advancing cycles (1..7).
- FLUSH_CYC, 1, cycles the decode slot is killed after i_flush (1..3).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_ID_valid  in  1  decode stage holds an instruction
- o_ID_ready  out  1  decode instruction consumed this cycle (issued or killed)
- i_ID_rs1  in  5  source register 1
- i_ID_rs2  in  5  source register 2
- i_ID_use_rs1  in  1  instruction reads rs1
- i_ID_use_rs2  in  1  instruction reads rs2
- i_ID_rd  in  5  destination register
- i_ID_reg_wr_en  in  1  instruction writes rd
- i_ID_src_rd  in  2  writeback source; 2'b01 = memory load
- o_EX_valid  out  1  instruction issued to execute this cycle
- i_EX_ready  in  1  execute stage can accept
- i_flush  in  1  taken branch/jump resolved in execute
- o_stall  out  1  load-use hazard is holding decode
- o_stall_cycles  out  32  performance stall count (see Optional Feature)

Behaviour:
- Reset is synchronous on i_rstn=0. State -> RUN, flush counter -> 0, all scoreboard counters -> 0, o_stall_cycles -> 0.
- While i_rstn=0: o_EX_valid=0, o_ID_ready=0, o_stall=0.
- Scoreboard holds one counter per register, width clog2(LOAD_LAT+1). Counter for x0 is hard-wired 0.
- Advance cycle = i_EX_ready=1. Scoreboard counters only decrement on advance cycles, saturating at 0.
- Hazard = i_ID_valid & ((i_ID_use_rs1 & cnt[rs1]!=0) | (i_ID_use_rs2 & cnt[rs2]!=0)).
- State RUN:
  - issue = i_ID_valid & ~hazard & i_EX_ready.
  - o_EX_valid = issue; o_ID_ready = issue; o_stall = hazard.
  - If issue & i_ID_src_rd==2'b01 & i_ID_reg_wr_en & rd!=0, then cnt[rd] <= LOAD_LAT.
  - Setting a counter takes priority over decrementing the same entry in that cycle.
  - i_flush=1 -> state FLUSH, flush counter <= FLUSH_CYC. That cycle: o_EX_valid=0, o_ID_ready=1 (kill); no scoreboard set, decrement still applies.
- State FLUSH:
  - o_EX_valid=0, o_ID_ready=1, o_stall=0.
  - Flush counter decrements each cycle; at 1, state -> RUN.
  - A new i_flush reloads the counter to FLUSH_CYC.
- Scoreboard is not cleared on flush: loads already issued still complete.
- Hazard with i_EX_ready=0: no issue; o_stall still reflects the hazard.
- i_ID_valid=0: o_ID_ready=0, o_EX_valid=0, o_stall=0.
- Counters reach 0 exactly LOAD_LAT advance cycles after load issue. A dependent instruction issues on the cycle the counter reads 0.
- Back-to-back loads to the same rd: the later load reloads the counter to LOAD_LAT.
- Reset mid-stall or mid-flush: next cycle is RUN with an empty scoreboard.

Optional Feature:
- Macro: RISCV_ISSUE_PERF_EN.
- Defined: o_stall_cycles increments by 1 each cycle o_stall=1 and i_rstn=1, wrapping 0xFFFFFFFF -> 0. Flush cycles are not counted.
- Undefined: o_stall_cycles is constant 0 and no counter register is built.

Test Plan:
- Load-use stall: LOAD_LAT=2, issue a load with rd=5, then an add using rs1=5 with i_EX_ready=1.
  -> o_stall=1 for 2 cycles, the add issues on cycle 3, o_stall_cycles=2.
- No hazard through x0: a load with rd=0, then an instruction using rs1=0.
  -> issues next cycle, o_stall=0.
- Flush: FLUSH_CYC=1, i_flush pulsed while i_ID_valid=1.
  -> o_EX_valid=0 and o_ID_ready=1 for that cycle and the next; RUN issues on the cycle after.
- Downstream backpressure: load rd=7 issued, then i_EX_ready=0 for 3 cycles with a dependent instruction in decode.
  -> cnt[7] stays 2, no issue; after i_EX_ready=1 the dependent issues 2 cycles later.
- Re-set vs decrement: load rd=3, one advance cycle, then a second load rd=3.
  -> cnt[3]=2 after the second issue; a dependent stalls 2 more cycles.
- Reset mid-stall: assert i_rstn=0 for 1 cycle while o_stall=1.
  -> after release, the dependent issues immediately; counter (PERF_EN) reads 0.

Source files
------------

// File: rtl/riscv_issue_ctrl.sv
// riscv_issue_ctrl: issue/hazard controller between decode and execute.
// Tracks in-flight load destinations with a per-register countdown
// scoreboard, stalls decode on load-use hazards and kills the decode slot
// for FLUSH_CYC cycles after a taken branch/jump flush.
// Optional feature macro: RISCV_ISSUE_PERF_EN builds a 32-bit stall-cycle
// performance counter on o_stall_cycles; without it the port is tied to 0.
module riscv_issue_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_ID_valid,
  output logic        o_ID_ready,
  input  logic [4:0]  i_ID_rs1,
  input  logic [4:0]  i_ID_rs2,
  input  logic        i_ID_use_rs1,
  input  logic        i_ID_use_rs2,
  input  logic [4:0]  i_ID_rd,
  input  logic        i_ID_reg_wr_en,
  input  logic [1:0]  i_ID_src_rd,
  output logic        o_EX_valid,
  input  logic        i_EX_ready,
  input  logic        i_flush,
  output logic        o_stall,
  output logic [31:0] o_stall_cycles
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]   cnt_q [NUM_REGS];
  logic [CW-1:0]   cnt_d [NUM_REGS];
  logic            rs1_busy, rs2_busy;
  logic            hazard, issue, load_set;

  // Look up whether either source register still waits on a load (x0 never does)
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (i_ID_rs1 != 5'd0 && int'(i_ID_rs1) < NUM_REGS) rs1_busy = (cnt_q[i_ID_rs1] != '0);
    if (i_ID_rs2 != 5'd0 && int'(i_ID_rs2) < NUM_REGS) rs2_busy = (cnt_q[i_ID_rs2] != '0);
    hazard = i_ID_valid & ((i_ID_use_rs1 & rs1_busy) | (i_ID_use_rs2 & rs2_busy));
  end

  // Next-state and handshake outputs; a flush kills the slot and overrides the hazard
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    issue       = 1'b0;
    load_set    = 1'b0;
    o_EX_valid  = 1'b0;
    o_ID_ready  = 1'b0;
    o_stall     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_flush) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 2'(FLUSH_CYC);
          o_ID_ready  = i_ID_valid;
        end else begin
          issue      = i_ID_valid & ~hazard & i_EX_ready;
          o_EX_valid = issue;
          o_ID_ready = issue;
          o_stall    = hazard;
          load_set   = issue & (i_ID_src_rd == 2'b01) & i_ID_reg_wr_en & (i_ID_rd != 5'd0);
        end
      end
      ST_FLUSH: begin
        o_ID_ready = i_ID_valid;
        if (i_flush) begin
          flush_cnt_d = 2'(FLUSH_CYC);
        end else if (flush_cnt_q == 2'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = 2'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 2'd0;
      end
    endcase
    if (!i_rstn) begin
      o_EX_valid = 1'b0;
      o_ID_ready = 1'b0;
      o_stall    = 1'b0;
      load_set   = 1'b0;
    end
  end

  // Scoreboard update: decrement on advance cycles, a new load overrides the decrement
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_EX_ready && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      if (load_set && int'(i_ID_rd) == i) cnt_d[i] = CW'(LOAD_LAT);
    end
    cnt_d[0] = '0;
  end

  // State, flush counter and scoreboard registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef RISCV_ISSUE_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Count cycles where decode is held by a load-use hazard (wraps naturally)
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'b0, o_stall};
  end

  // Performance counter register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) stall_cycles_q <= 32'd0;
    else         stall_cycles_q <= stall_cycles_d;
  end

  assign o_stall_cycles = stall_cycles_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule
